// File: rtl/bht_update_queue_if.sv
// Producer/consumer bundle for the BHT update queue: two commit-port resolutions in,
// one BHT update out.
interface bht_update_queue_if #(
  parameter int VLEN = 64
) ();
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  // res_valid_i is fire-and-forget: ready_o is advisory, and a resolution with no free
  // slot is dropped and counted. bht_update_o.valid means the update is consumed that
  // same cycle, because the BHT has no back-pressure.
  logic [1:0]           res_valid_i;
  logic [1:0][VLEN-1:0] res_pc_i;
  logic [1:0]           res_taken_i;
  logic                 ready_o;
  bht_update_t          bht_update_o;

  modport master (
    output res_valid_i, res_pc_i, res_taken_i,
    input  ready_o, bht_update_o
  );

  modport slave (
    input  res_valid_i, res_pc_i, res_taken_i,
    output ready_o, bht_update_o
  );
endinterface

// File: rtl/bht_update_queue.sv
// In-order queue of resolved branch outcomes. It takes up to two per cycle and replays
// one per cycle into the BHT update port.
module bht_update_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter int VLEN  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  bht_update_queue_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic [CNT_W-1:0]           drop_cnt_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int SPW   = CW + 1;

  logic [VLEN-1:0]  pc_q    [DEPTH];
  logic             taken_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q, tail_d, wr1_idx;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W:0]   drop_sum;
  logic [SPW-1:0]   space;
  logic             en, deq, acc0, acc1, drop0, drop1;

  always_comb begin
    en    = !flush_i && !debug_mode_i;
    deq   = (count_q != '0) && en;
    // A same-cycle dequeue frees a slot for the incoming resolutions.
    space = SPW'(DEPTH) - {1'b0, count_q} + SPW'(deq);
    acc0  = en && bus.res_valid_i[0] && (space != '0);
    acc1  = en && bus.res_valid_i[1] && (space >= (SPW'(acc0) + SPW'(1)));
    drop0 = en && bus.res_valid_i[0] && !acc0;
    drop1 = en && bus.res_valid_i[1] && !acc1;

    wr1_idx = tail_q + PTR_W'(acc0);
    tail_d  = tail_q + PTR_W'(acc0) + PTR_W'(acc1);
    count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(deq);

    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop0) + (CNT_W+1)'(drop1);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        taken_q[i] <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (acc0) begin
        pc_q[tail_q]    <= bus.res_pc_i[0];
        taken_q[tail_q] <= bus.res_taken_i[0];
      end
      if (acc1) begin
        pc_q[wr1_idx]    <= bus.res_pc_i[1];
        taken_q[wr1_idx] <= bus.res_taken_i[1];
      end
      head_q  <= head_q + PTR_W'(deq);
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.bht_update_o = {deq, pc_q[head_q], taken_q[head_q]};
  assign bus.ready_o      = (count_q <= CW'(DEPTH - 2));
  assign usage_o          = count_q;
  assign drop_cnt_o       = drop_q;
endmodule

// File: tb/tb_bht_update_queue.sv
// Bench for bht_update_queue: a queue-based reference model with a per-cycle compare,
// plus directed vectors with literal expectations.
module tb_bht_update_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int VLEN  = 32;
  localparam int MAXD  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic flush, dbg;
  logic [$clog2(DEPTH+1)-1:0] usage;
  logic [CNT_W-1:0]           drop;
  logic [VLEN+1:0]            upd;
  logic                       upd_v, upd_t;
  logic [VLEN-1:0]            upd_pc;

  int vectors     = 0;
  int miscompares = 0;

  logic [VLEN:0] exp_q[$];
  int            mdrop = 0;

  bht_update_queue_if #(.VLEN(VLEN)) bus ();

  bht_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .VLEN(VLEN)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .debug_mode_i (dbg),
    .bus          (bus),
    .usage_o      (usage),
    .drop_cnt_o   (drop)
  );

  // clock
  always #5 clk = ~clk;

  assign upd    = bus.bht_update_o;
  assign upd_v  = upd[VLEN+1];
  assign upd_pc = upd[VLEN:1];
  assign upd_t  = upd[0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] v, input logic [VLEN-1:0] p0, input logic t0,
                       input logic [VLEN-1:0] p1, input logic t1, input logic fl, input logic dm);
    bus.res_valid_i    = v;
    bus.res_pc_i[0]    = p0;
    bus.res_taken_i[0] = t0;
    bus.res_pc_i[1]    = p1;
    bus.res_taken_i[1] = t1;
    flush              = fl;
    dbg                = dm;
  endtask

  task automatic idle();
    drive(2'b00, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // reference model: pop first, then push while there is room
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      mdrop = 0;
    end else if (flush) begin
      exp_q.delete();
    end else if (!dbg) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      for (int p = 0; p < 2; p++) begin
        if (bus.res_valid_i[p]) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({bus.res_pc_i[p], bus.res_taken_i[p]});
          else if (mdrop < MAXD) mdrop++;
        end
      end
    end
  end

  // scoreboard compare
  always @(negedge clk) begin
    if (!rst) begin
      logic ev;
      ev = (exp_q.size() != 0) && !flush && !dbg;
      chk("m_valid", 64'(upd_v), 64'(ev));
      if (ev) begin
        chk("m_pc", 64'(upd_pc), 64'(exp_q[0][VLEN:1]));
        chk("m_taken", 64'(upd_t), 64'(exp_q[0][0]));
      end
      chk("m_usage", 64'(usage), 64'(exp_q.size()));
      chk("m_drop", 64'(drop), 64'(mdrop));
      chk("m_ready", 64'(bus.ready_o), 64'((DEPTH - exp_q.size()) >= 2));
    end
  end

  initial begin
    logic [VLEN-1:0] ovf_pc [3];
    logic            dbg_r;
    rst = 1'b0;
    idle();
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(upd_v), 0);
    chk("rst_pc", 64'(upd_pc), 0);
    chk("rst_usage", 64'(usage), 0);
    chk("rst_drop", 64'(drop), 0);
    chk("rst_ready", 64'(bus.ready_o), 1);
    next(); next();
    rst = 1'b0;

    // ordering: two entries into an empty queue
    drive(2'b11, 'h100, 1'b1, 'h104, 1'b0, 1'b0, 1'b0);
    @(negedge clk) chk("ord_empty_v", 64'(upd_v), 0);
    next(); idle();
    @(negedge clk);
    chk("ord0_v", 64'(upd_v), 1); chk("ord0_pc", 64'(upd_pc), 'h100);
    chk("ord0_t", 64'(upd_t), 1); chk("ord0_use", 64'(usage), 2);
    next();
    @(negedge clk);
    chk("ord1_v", 64'(upd_v), 1); chk("ord1_pc", 64'(upd_pc), 'h104);
    chk("ord1_t", 64'(upd_t), 0); chk("ord1_use", 64'(usage), 1);
    next();
    @(negedge clk);
    chk("ord2_v", 64'(upd_v), 0); chk("ord2_use", 64'(usage), 0);
    next();

    // debug hold
    drive(2'b11, 'h200, 1'b1, 'h204, 1'b0, 1'b0, 1'b0);
    next();
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, VLEN'('h300 + 8*k), 1'b1, VLEN'('h304 + 8*k), 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("dbg_v", 64'(upd_v), 0); chk("dbg_use", 64'(usage), 2); chk("dbg_drop", 64'(drop), 0);
      next();
    end
    idle();
    @(negedge clk) chk("dbg_rel0_pc", 64'(upd_pc), 'h200);
    next();
    @(negedge clk) chk("dbg_rel1_pc", 64'(upd_pc), 'h204);
    next();
    @(negedge clk) chk("dbg_rel2_v", 64'(upd_v), 0);

    // overflow: fill to 4, freeze, then two inputs per cycle
    drive(2'b11, 'h400, 1'b0, 'h404, 1'b1, 1'b0, 1'b0); next();
    drive(2'b11, 'h408, 1'b0, 'h40c, 1'b1, 1'b0, 1'b0); next();
    drive(2'b11, 'h410, 1'b0, 'h414, 1'b1, 1'b0, 1'b0); next();
    drive(2'b00, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovf_full_use", 64'(usage), 4); chk("ovf_full_v", 64'(upd_v), 0);
    chk("ovf_full_ready", 64'(bus.ready_o), 0);
    next(); next();
    ovf_pc[0] = 'h408; ovf_pc[1] = 'h40c; ovf_pc[2] = 'h410;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, VLEN'('h500 + 16*k), 1'b1, VLEN'('h504 + 16*k), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("ovf_pc", 64'(upd_pc), 64'(ovf_pc[k]));
      chk("ovf_drop", 64'(drop), 64'(k));
      next();
    end
    idle();
    @(negedge clk);
    chk("ovf_end_use", 64'(usage), 4); chk("ovf_end_drop", 64'(drop), 3);
    chk("ovf_end_pc", 64'(upd_pc), 'h414);
    next();

    // flush with three entries queued and an input present
    drive(2'b01, 'h600, 1'b1, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk) chk("fl_v", 64'(upd_v), 0);
    next(); idle();
    @(negedge clk);
    chk("fl_use", 64'(usage), 0); chk("fl_v_after", 64'(upd_v), 0); chk("fl_drop", 64'(drop), 3);
    next();

    // random traffic with sustained overflow, checked by the model
    dbg_r = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(3, 0));
      if ($urandom_range(3, 0) != 0) v = 2'b11;
      if ($urandom_range(15, 0) == 0) dbg_r = ~dbg_r;
      drive(v, VLEN'($urandom()), 1'($urandom_range(1, 0)), VLEN'($urandom()),
            1'($urandom_range(1, 0)), ($urandom_range(49, 0) == 0), dbg_r);
      next();
    end
    idle();
    @(negedge clk) chk("sat_drop", 64'(drop), 3);
    next();

    // asynchronous reset mid-stream with three entries queued
    drive(2'b00, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0); next();
    drive(2'b11, 'h700, 1'b1, 'h704, 1'b0, 1'b0, 1'b0); next();
    drive(2'b11, 'h708, 1'b1, 'h70c, 1'b0, 1'b0, 1'b0); next();
    idle();
    chk("pre_rst_use", 64'(usage), 3);
    rst = 1'b1;
    #1;
    chk("arst_v", 64'(upd_v), 0); chk("arst_use", 64'(usage), 0);
    chk("arst_drop", 64'(drop), 0); chk("arst_ready", 64'(bus.ready_o), 1);
    next(); next();
    rst = 1'b0;
    @(negedge clk) chk("post_rst_use", 64'(usage), 0);
    next();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
